axi4_master_bridge: RTL and testbench

- Initiator-side AXI4 bridge: turns a simple core-side request/stream interface into AXI4 INCR read and write bursts on the io_master bus.
- Drives the same AXI4 master port set that the SoC top connects to the AXI memory slave.
- One outstanding transaction at a time. Used by the core's IFU/LSU/cache refill path.

---
 rtl/axi4_master_bridge.sv | 260 ++++++++++++++++++++++++++
 tb/tb_axi4_master_bridge.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_master_bridge.sv
`timescale 1ns/1ps
// axi4_master_bridge
// Turns a simple core request/stream interface into AXI4 INCR read and write
// bursts. Only one transaction is in flight at a time. Read beats and write
// completions come back to the core as one-cycle rsp pulses, one cycle after
// the AXI handshake that produced them.
module axi4_master_bridge #(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 64,
    parameter int              ID_W   = 4,
    parameter logic [ID_W-1:0] AXI_ID = '0
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [7:0]          req_len,
    input  logic [2:0]          req_size,
    input  logic                wd_valid,
    output logic                wd_ready,
    input  logic [DATA_W-1:0]   wd_data,
    input  logic [DATA_W/8-1:0] wd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_last,
    output logic                rsp_err,
    output logic                io_master_awvalid,
    input  logic                io_master_awready,
    output logic [ID_W-1:0]     io_master_awid,
    output logic [ADDR_W-1:0]   io_master_awaddr,
    output logic [7:0]          io_master_awlen,
    output logic [2:0]          io_master_awsize,
    output logic [1:0]          io_master_awburst,
    output logic                io_master_wvalid,
    input  logic                io_master_wready,
    output logic [DATA_W-1:0]   io_master_wdata,
    output logic [DATA_W/8-1:0] io_master_wstrb,
    output logic                io_master_wlast,
    input  logic                io_master_bvalid,
    output logic                io_master_bready,
    input  logic [ID_W-1:0]     io_master_bid,
    input  logic [1:0]          io_master_bresp,
    output logic                io_master_arvalid,
    input  logic                io_master_arready,
    output logic [ID_W-1:0]     io_master_arid,
    output logic [ADDR_W-1:0]   io_master_araddr,
    output logic [7:0]          io_master_arlen,
    output logic [2:0]          io_master_arsize,
    output logic [1:0]          io_master_arburst,
    input  logic                io_master_rvalid,
    output logic                io_master_rready,
    input  logic [ID_W-1:0]     io_master_rid,
    input  logic [1:0]          io_master_rresp,
    input  logic [DATA_W-1:0]   io_master_rdata,
    input  logic                io_master_rlast
);

    localparam logic [1:0] BURST_INCR = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RADDR = 3'd1,
        S_RDATA = 3'd2,
        S_WRITE = 3'd3,
        S_WRESP = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [2:0]          size_q, size_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                arvalid_q, arvalid_d;
    logic                awvalid_q, awvalid_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                rsp_last_q, rsp_last_d;
    logic                rsp_err_q, rsp_err_d;

    logic w_active;
    logic ar_hs, aw_hs, w_hs, r_hs, b_hs;
    logic beat_err;
    logic last_w_now;
    logic aw_now;

    // Channel-level control derived from the current state
    always_comb begin
        w_active          = (state_q == S_WRITE) && !w_done_q;
        req_ready         = (state_q == S_IDLE);
        io_master_rready  = (state_q == S_RDATA);
        io_master_bready  = (state_q == S_WRESP);
        io_master_wvalid  = w_active && wd_valid;
        wd_ready          = w_active && io_master_wready;
        io_master_wlast   = w_active && (cnt_q == len_q);
        io_master_wdata   = wd_data;
        io_master_wstrb   = wd_strb;

        ar_hs = arvalid_q && io_master_arready;
        aw_hs = awvalid_q && io_master_awready;
        w_hs  = io_master_wvalid && io_master_wready;
        r_hs  = io_master_rready && io_master_rvalid;
        b_hs  = io_master_bready && io_master_bvalid;

        // A read beat is bad on a non-OKAY response, a foreign ID, or when
        // rlast disagrees with whether this is beat number len.
        beat_err = (io_master_rresp != 2'b00) || (io_master_rid != AXI_ID) ||
                   (io_master_rlast != (cnt_q == len_q));

        last_w_now = w_done_q || (w_hs && (cnt_q == len_q));
        aw_now     = aw_done_q || aw_hs;
    end

    // Next-state and next-output computation for the transaction FSM
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        cnt_d       = cnt_q;
        err_d       = err_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        arvalid_d   = arvalid_q;
        awvalid_d   = awvalid_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_last_d  = rsp_last_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d    = req_addr;
                    len_d     = req_len;
                    size_d    = req_size;
                    cnt_d     = 8'd0;
                    err_d     = 1'b0;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    if (req_write) begin
                        awvalid_d = 1'b1;
                        state_d   = S_WRITE;
                    end else begin
                        arvalid_d = 1'b1;
                        state_d   = S_RADDR;
                    end
                end
            end
            S_RADDR: begin
                if (ar_hs) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RDATA;
                end
            end
            S_RDATA: begin
                if (r_hs) begin
                    cnt_d       = cnt_q + 8'd1;
                    err_d       = err_q || beat_err;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = io_master_rdata;
                    rsp_last_d  = io_master_rlast;
                    rsp_err_d   = err_q || beat_err;
                    // rlast always ends the burst, early or not
                    if (io_master_rlast) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_WRITE: begin
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    // separate done flag: with len=255 the counter wraps to 0
                    if (cnt_q == len_q) begin
                        w_done_d = 1'b1;
                    end
                end
                if (aw_now && last_w_now) begin
                    state_d = S_WRESP;
                end
            end
            S_WRESP: begin
                if (b_hs) begin
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = '0;
                    rsp_last_d  = 1'b1;
                    rsp_err_d   = (io_master_bresp != 2'b00) || (io_master_bid != AXI_ID);
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops everything immediately
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            cnt_q       <= 8'd0;
            err_q       <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            awvalid_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_last_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            arvalid_q   <= arvalid_d;
            awvalid_q   <= awvalid_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_last_q  <= rsp_last_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Address-channel fields are the captured request, held until handshake
    always_comb begin
        io_master_arvalid = arvalid_q;
        io_master_arid    = AXI_ID;
        io_master_araddr  = addr_q;
        io_master_arlen   = len_q;
        io_master_arsize  = size_q;
        io_master_arburst = BURST_INCR;
        io_master_awvalid = awvalid_q;
        io_master_awid    = AXI_ID;
        io_master_awaddr  = addr_q;
        io_master_awlen   = len_q;
        io_master_awsize  = size_q;
        io_master_awburst = BURST_INCR;
        rsp_valid         = rsp_valid_q;
        rsp_data          = rsp_data_q;
        rsp_last          = rsp_last_q;
        rsp_err           = rsp_err_q;
    end

endmodule

// File: tb/tb_axi4_master_bridge.sv
`timescale 1ns/1ps
// Testbench for axi4_master_bridge: acts as both core and AXI slave, with a
// transaction-level model of the expected rsp pulses.
module tb_axi4_master_bridge;

    localparam int         ADDR_W = 32;
    localparam int         DATA_W = 64;
    localparam int         ID_W   = 4;
    localparam logic [3:0] AXI_ID = 4'd0;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [7:0]  req_len;
    logic [2:0]  req_size;
    logic        wd_valid, wd_ready;
    logic [63:0] wd_data;
    logic [7:0]  wd_strb;
    logic        rsp_valid, rsp_last, rsp_err;
    logic [63:0] rsp_data;
    logic        io_master_awvalid, io_master_awready;
    logic [3:0]  io_master_awid;
    logic [31:0] io_master_awaddr;
    logic [7:0]  io_master_awlen;
    logic [2:0]  io_master_awsize;
    logic [1:0]  io_master_awburst;
    logic        io_master_wvalid, io_master_wready, io_master_wlast;
    logic [63:0] io_master_wdata;
    logic [7:0]  io_master_wstrb;
    logic        io_master_bvalid, io_master_bready;
    logic [3:0]  io_master_bid;
    logic [1:0]  io_master_bresp;
    logic        io_master_arvalid, io_master_arready;
    logic [3:0]  io_master_arid;
    logic [31:0] io_master_araddr;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rvalid, io_master_rready, io_master_rlast;
    logic [3:0]  io_master_rid;
    logic [1:0]  io_master_rresp;
    logic [63:0] io_master_rdata;

    axi4_master_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .AXI_ID(AXI_ID)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last), .rsp_err(rsp_err),
        .io_master_awvalid(io_master_awvalid), .io_master_awready(io_master_awready),
        .io_master_awid(io_master_awid), .io_master_awaddr(io_master_awaddr),
        .io_master_awlen(io_master_awlen), .io_master_awsize(io_master_awsize),
        .io_master_awburst(io_master_awburst),
        .io_master_wvalid(io_master_wvalid), .io_master_wready(io_master_wready),
        .io_master_wdata(io_master_wdata), .io_master_wstrb(io_master_wstrb),
        .io_master_wlast(io_master_wlast),
        .io_master_bvalid(io_master_bvalid), .io_master_bready(io_master_bready),
        .io_master_bid(io_master_bid), .io_master_bresp(io_master_bresp),
        .io_master_arvalid(io_master_arvalid), .io_master_arready(io_master_arready),
        .io_master_arid(io_master_arid), .io_master_araddr(io_master_araddr),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst),
        .io_master_rvalid(io_master_rvalid), .io_master_rready(io_master_rready),
        .io_master_rid(io_master_rid), .io_master_rresp(io_master_rresp),
        .io_master_rdata(io_master_rdata), .io_master_rlast(io_master_rlast)
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] data;
        logic        last;
        logic        err;
    } rsp_t;
    rsp_t exp_q[$];

    // current transaction description
    logic        t_write;
    logic [31:0] t_addr;
    logic [7:0]  t_len;
    logic [2:0]  t_size;
    logic [63:0] t_data  [0:256];
    logic [7:0]  t_strb  [0:256];
    logic [1:0]  t_rresp [0:256];
    logic [3:0]  t_rid, t_bid;
    logic [1:0]  t_bresp;
    int          t_last_idx, t_ar_delay, t_aw_delay, t_b_delay, t_rgap, t_wgap;
    bit          t_wready_all;

    int          m_ar_cycles, m_aw_wbeats;
    int          rsp_seen = 0;
    logic [63:0] last_rsp_data;
    logic        last_rsp_last, last_rsp_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic set_txn(input logic wr, input logic [31:0] a, input logic [7:0] l, input logic [2:0] s);
        t_write = wr; t_addr = a; t_len = l; t_size = s;
        for (int i = 0; i <= 256; i++) begin
            t_data[i]  = {$urandom, $urandom};
            t_strb[i]  = 8'($urandom);
            t_rresp[i] = 2'b00;
        end
        t_rid = AXI_ID; t_bid = AXI_ID; t_bresp = 2'b00;
        t_last_idx = int'(l);
        t_ar_delay = 0; t_aw_delay = 0; t_b_delay = 0; t_rgap = 0; t_wgap = 0;
        t_wready_all = 1'b1;
    endtask

    // Reference: the list of rsp pulses a transaction must produce
    task automatic build_expected();
        rsp_t r;
        logic err;
        err = 1'b0;
        if (!t_write) begin
            for (int i = 0; i <= t_last_idx; i++) begin
                if (t_rresp[i] != 2'b00 || t_rid != AXI_ID) err = 1'b1;
                if ((i == t_last_idx) != (i == int'(t_len))) err = 1'b1;
                r.data = t_data[i];
                r.last = (i == t_last_idx);
                r.err  = err;
                exp_q.push_back(r);
            end
        end else begin
            r.data = 64'd0;
            r.last = 1'b1;
            r.err  = (t_bresp != 2'b00) || (t_bid != AXI_ID);
            exp_q.push_back(r);
        end
    endtask

    task automatic zero_drives();
        req_valid = 0; req_write = 0; req_addr = 0; req_len = 0; req_size = 0;
        wd_valid = 0; wd_data = 0; wd_strb = 0;
        io_master_awready = 0; io_master_wready = 0; io_master_arready = 0;
        io_master_bvalid = 0; io_master_bid = 0; io_master_bresp = 0;
        io_master_rvalid = 0; io_master_rid = 0; io_master_rresp = 0;
        io_master_rdata = 0; io_master_rlast = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock); #1;
            zero_drives();
        end
    endtask

    // Runs one transaction as core + slave; drives at posedge+1, observes at negedge
    task automatic run_txn(input bit b2b, input int abort_after);
        int cyc = 0, ar_seen = 0, aw_seen = 0, b_wait = 0, r_beat = 0, w_beat = 0, ar_vc = 0;
        bit req_done = 0, ar_done = 0, aw_done = 0, done = 0, aborted = 0;
        bit n_req, n_arr, n_awr, n_rv, n_wdv, n_wr, n_bv;
        bit req_hs, ar_hs, aw_hs, w_hs, r_hs, b_hs;
        build_expected();
        n_req = 1; n_arr = (t_ar_delay == 0); n_awr = (t_aw_delay == 0); n_rv = 0; n_bv = 0;
        n_wdv = t_write && ($urandom_range(0, 99) >= t_wgap);
        n_wr  = t_wready_all || ($urandom_range(0, 1) == 1);
        m_aw_wbeats = -1;
        m_ar_cycles = -1;
        while (!done) begin
            @(posedge clock); #1;
            req_valid = n_req; req_write = t_write; req_addr = t_addr; req_len = t_len; req_size = t_size;
            io_master_arready = n_arr; io_master_awready = n_awr;
            io_master_rvalid = n_rv; io_master_rdata = t_data[r_beat];
            io_master_rlast = (r_beat == t_last_idx); io_master_rresp = t_rresp[r_beat]; io_master_rid = t_rid;
            wd_valid = n_wdv; wd_data = t_data[w_beat]; wd_strb = t_strb[w_beat]; io_master_wready = n_wr;
            io_master_bvalid = n_bv; io_master_bresp = t_bresp; io_master_bid = t_bid;
            @(negedge clock);
            cyc++;
            if (b2b && cyc == 1) chk("b2b_req_ready", req_ready, 1);
            req_hs = req_valid && req_ready;
            ar_hs  = io_master_arvalid && io_master_arready;
            aw_hs  = io_master_awvalid && io_master_awready;
            w_hs   = io_master_wvalid && io_master_wready;
            r_hs   = io_master_rvalid && io_master_rready;
            b_hs   = io_master_bvalid && io_master_bready;
            if (req_hs) req_done = 1;
            if (io_master_arvalid && !ar_done) ar_vc++;
            if (ar_hs) begin
                chk("araddr", io_master_araddr, t_addr);
                chk("arlen", io_master_arlen, t_len);
                chk("arsize", io_master_arsize, t_size);
                chk("arburst", io_master_arburst, 2'b01);
                chk("arid", io_master_arid, AXI_ID);
                ar_done = 1;
                m_ar_cycles = ar_vc;
            end
            if (aw_hs) begin
                chk("awaddr", io_master_awaddr, t_addr);
                chk("awlen", io_master_awlen, t_len);
                chk("awsize", io_master_awsize, t_size);
                chk("awburst", io_master_awburst, 2'b01);
                chk("awid", io_master_awid, AXI_ID);
                aw_done = 1;
                m_aw_wbeats = w_beat;
            end
            if (t_write) chk("wd_ready_hs", wd_valid && wd_ready, w_hs);
            if (w_hs) begin
                chk("wdata", io_master_wdata, t_data[w_beat]);
                chk("wstrb", io_master_wstrb, t_strb[w_beat]);
                chk("wlast", io_master_wlast, w_beat == int'(t_len));
                w_beat++;
            end
            if (r_hs) begin
                if (r_beat == t_last_idx) done = 1;
                r_beat++;
                if (abort_after > 0 && r_beat == abort_after) begin
                    aborted = 1;
                    done = 1;
                end
            end
            if (b_hs) done = 1;
            n_req = !req_done;
            if (ar_done) n_arr = 0;
            else if (io_master_arvalid) begin ar_seen++; n_arr = (ar_seen >= t_ar_delay); end
            if (aw_done) n_awr = 0;
            else if (io_master_awvalid) begin aw_seen++; n_awr = (aw_seen >= t_aw_delay); end
            if (io_master_rvalid && !r_hs) n_rv = 1;
            else n_rv = ar_done && (r_beat <= t_last_idx) && ($urandom_range(0, 99) >= t_rgap);
            if (wd_valid && !(wd_valid && wd_ready)) n_wdv = 1;
            else n_wdv = t_write && (w_beat <= int'(t_len)) && ($urandom_range(0, 99) >= t_wgap);
            n_wr = t_wready_all || ($urandom_range(0, 1) == 1);
            if (io_master_bvalid && !b_hs) n_bv = 1;
            else if (t_write && aw_done && w_beat > int'(t_len) && !b_hs) begin
                if (b_wait >= t_b_delay) n_bv = 1;
                else begin b_wait++; n_bv = 0; end
            end else n_bv = 0;
            if (cyc > 3000 && !done) begin
                checks++;
                errors++;
                $display("FAIL txn_timeout: actual=%0d cycles required<=3000", cyc);
                done = 1;
            end
        end
        if (aborted) begin
            @(negedge clock);
            #2;
            reset = 1'b0;
            zero_drives();
            #1;
            chk("rst_arvalid", io_master_arvalid, 0);
            chk("rst_rready", io_master_rready, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_data", rsp_data, 0);
            chk("rst_req_ready", req_ready, 1);
            chk("rst_awvalid", io_master_awvalid, 0);
            exp_q.delete();
            repeat (2) @(negedge clock);
            reset = 1'b1;
            @(negedge clock);
            chk("post_rst_req_ready", req_ready, 1);
        end
    endtask

    // Compare process: rsp outputs versus the model on every cycle
    initial begin : compare
        rsp_t        exp_cur;
        bit          exp_valid;
        bit          prev_arv, prev_arr;
        logic [31:0] prev_araddr;
        exp_valid = 0; prev_arv = 0; prev_arr = 0; prev_araddr = 0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                exp_valid = 0; prev_arv = 0; prev_arr = 0;
            end else begin
                chk("rsp_valid", rsp_valid, exp_valid);
                if (exp_valid) begin
                    chk("rsp_data", rsp_data, exp_cur.data);
                    chk("rsp_last", rsp_last, exp_cur.last);
                    chk("rsp_err", rsp_err, exp_cur.err);
                end
                if (rsp_valid) begin
                    rsp_seen++;
                    last_rsp_data = rsp_data;
                    last_rsp_last = rsp_last;
                    last_rsp_err  = rsp_err;
                end
                chk("ar_aw_overlap", io_master_arvalid && io_master_awvalid, 0);
                if (prev_arv && !prev_arr) begin
                    chk("arvalid_stable", io_master_arvalid, 1);
                    chk("araddr_stable", io_master_araddr, prev_araddr);
                end
                prev_arv = io_master_arvalid;
                prev_arr = io_master_arready;
                prev_araddr = io_master_araddr;
                exp_valid = 0;
                if ((io_master_rvalid && io_master_rready) || (io_master_bvalid && io_master_bready)) begin
                    chk("hs_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        exp_cur = exp_q.pop_front();
                        exp_valid = 1;
                    end
                end
            end
        end
    end

    initial begin : main
        int base;
        zero_drives();
        repeat (3) @(negedge clock);
        chk("reset_req_ready", req_ready, 1);
        chk("reset_arvalid", io_master_arvalid, 0);
        chk("reset_awvalid", io_master_awvalid, 0);
        chk("reset_rready", io_master_rready, 0);
        chk("reset_bready", io_master_bready, 0);
        chk("reset_wd_ready", wd_ready, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_data", rsp_data, 0);
        reset = 1'b1;
        @(negedge clock);
        chk("release_req_ready", req_ready, 1);

        // single read
        set_txn(0, 32'h8000_0000, 8'd0, 3'd3);
        t_data[0] = 64'h1122_3344_5566_7788;
        base = rsp_seen;
        run_txn(0, 0);
        idle(3);
        chk("t1_pulses", rsp_seen - base, 1);
        chk("t1_data", last_rsp_data, 64'h1122_3344_5566_7788);
        chk("t1_last", last_rsp_last, 1);
        chk("t1_err", last_rsp_err, 0);

        // 4-beat read, arready delayed, rvalid gaps
        set_txn(0, 32'h8000_0040, 8'd3, 3'd3);
        for (int i = 0; i < 4; i++) t_data[i] = 64'hA0 + 64'(i);
        t_ar_delay = 3; t_rgap = 50;
        base = rsp_seen;
        run_txn(0, 0);
        idle(3);
        chk("t2_ar_cycles", m_ar_cycles, 4);
        chk("t2_pulses", rsp_seen - base, 4);
        chk("t2_data", last_rsp_data, 64'hA3);
        chk("t2_last", last_rsp_last, 1);

        // 2-beat write, W completes before AW
        set_txn(1, 32'h8000_0100, 8'd1, 3'd3);
        t_aw_delay = 6;
        base = rsp_seen;
        run_txn(0, 0);
        idle(3);
        chk("t3_w_before_aw", m_aw_wbeats, 2);
        chk("t3_pulses", rsp_seen - base, 1);
        chk("t3_last", last_rsp_last, 1);
        chk("t3_data", last_rsp_data, 0);
        chk("t3_err", last_rsp_err, 0);

        // bresp SLVERR
        set_txn(1, 32'h8000_0200, 8'd0, 3'd3);
        t_bresp = 2'b10;
        run_txn(0, 0);
        idle(3);
        chk("t4_bresp_err", last_rsp_err, 1);

        // wrong rid
        set_txn(0, 32'h8000_0300, 8'd1, 3'd3);
        t_rid = 4'd5;
        run_txn(0, 0);
        idle(3);
        chk("t5_rid_err", last_rsp_err, 1);

        // early rlast on beat 1 of len=3
        set_txn(0, 32'h8000_0400, 8'd3, 3'd3);
        t_last_idx = 1;
        base = rsp_seen;
        run_txn(0, 0);
        idle(3);
        chk("t6_pulses", rsp_seen - base, 2);
        chk("t6_err", last_rsp_err, 1);
        chk("t6_last", last_rsp_last, 1);
        chk("t6_idle", req_ready, 1);

        // reset during RDATA after 2 of 4 beats, then a clean read
        set_txn(0, 32'h8000_0500, 8'd3, 3'd3);
        run_txn(0, 2);
        idle(2);
        set_txn(0, 32'h8000_0600, 8'd2, 3'd3);
        base = rsp_seen;
        run_txn(0, 0);
        idle(3);
        chk("t7_pulses", rsp_seen - base, 3);
        chk("t7_err", last_rsp_err, 0);

        // back-to-back read then write
        set_txn(0, 32'h8000_0700, 8'd1, 3'd3);
        run_txn(0, 0);
        set_txn(1, 32'h8000_0800, 8'd1, 3'd3);
        run_txn(1, 0);
        idle(3);

        // randomized back-to-back traffic
        for (int k = 0; k < 40; k++) begin
            logic [7:0] l;
            l = (k == 3 || k == 7) ? 8'd255 : 8'($urandom_range(0, 7));
            set_txn(k == 7 ? 1'b1 : (k == 3 ? 1'b0 : 1'($urandom_range(0, 1))),
                    $urandom & 32'hFFFF_FFF8, l, 3'($urandom_range(0, 3)));
            t_ar_delay = $urandom_range(0, 4);
            t_aw_delay = $urandom_range(0, 4);
            t_b_delay  = $urandom_range(0, 3);
            t_rgap = $urandom_range(0, 40);
            t_wgap = $urandom_range(0, 40);
            t_wready_all = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) t_rid = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 9) == 0) t_bid = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 7) == 0) t_bresp = 2'($urandom_range(1, 3));
            for (int i = 0; i <= int'(l); i++)
                if ($urandom_range(0, 29) == 0) t_rresp[i] = 2'($urandom_range(1, 3));
            if (l > 0 && $urandom_range(0, 7) == 0) t_last_idx = $urandom_range(0, int'(l) - 1);
            else if (l < 255 && $urandom_range(0, 7) == 0) t_last_idx = int'(l) + 1;
            run_txn(k > 0, 0);
        end
        idle(4);
        chk("model_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
